// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package ex_muldiv_sequencer_pkg;

  localparam int unsigned MULDIV_STATE_WIDTH = 2;

  typedef enum logic [MULDIV_STATE_WIDTH-1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // rs1 is interpreted as signed by MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is interpreted as signed by MULH, DIV and REM
  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_datapath.sv
// Magnitude datapath: shift-add multiply / restoring divide, sign fix, result select.
module ex_muldiv_sequencer_datapath
  import ex_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            last_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            fast_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  logic [2:0]      f3_q;
  logic [XLEN-1:0] opb_q;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q;       // product high half / partial remainder
  logic [XLEN-1:0] lo_q;       // multiplier+product low half / dividend+quotient
  logic            neg_q;      // product or quotient negative
  logic            rneg_q;     // remainder negative
  logic [XLEN-1:0] result_q;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, overflow;
  logic [XLEN-1:0] fast_val;
  logic [XLEN:0]   sum, shifted, diff;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, res_n;

  // Operand magnitudes and the divide fast-path results
  always_comb begin
    a_neg       = op_a_signed(funct3_i) & op_a_i[XLEN-1];
    b_neg       = op_b_signed(funct3_i) & op_b_i[XLEN-1];
    mag_a       = a_neg ? -op_a_i : op_a_i;
    mag_b       = b_neg ? -op_b_i : op_b_i;
    div_by_zero = (op_b_i == '0);
    overflow    = !funct3_i[0] && (op_a_i == MIN_VAL) && (op_b_i == ALL_ONES);
    fast_o      = funct3_i[2] & (div_by_zero | overflow);
    if (div_by_zero) fast_val = funct3_i[1] ? op_a_i : ALL_ONES;
    else             fast_val = funct3_i[1] ? '0 : MIN_VAL;
  end

  // One iteration step plus the sign-fixed result of that step
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opb_q};
    if (f3_q[2]) begin
      hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {hi_n, lo_n};
    prod_fix = neg_q  ? -prod : prod;
    quo_fix  = neg_q  ? -lo_n : lo_n;
    rem_fix  = rneg_q ? -hi_n : hi_n;
    if (f3_q[2])               res_n = f3_q[1] ? rem_fix : quo_fix;
    else if (f3_q[1:0] == 2'b00) res_n = prod_fix[XLEN-1:0];
    else                       res_n = prod_fix[2*XLEN-1:XLEN];
  end

  // Operand latch, iteration registers and the result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q     <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else if (load_i) begin
      f3_q   <= funct3_i;
      opb_q  <= mag_b;
      hi_q   <= '0;
      lo_q   <= mag_a;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      if (fast_o) result_q <= fast_val;
    end else if (step_i) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (last_i) result_q <= res_n;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: control FSM, iteration counter and pipeline stall.
module ex_muldiv_sequencer
  import ex_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  muldiv_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic accept_c, step_c, last_c, fast_c;

  // Handshake decode; stall must react to start in the same cycle
  always_comb begin
    accept_c = (state_q == MD_IDLE) & start_i & !flush_i;
    step_c   = ((state_q == MD_MUL) | (state_q == MD_DIV)) & !flush_i;
    last_c   = (cnt_q == '0);
  end

  assign stall_o = accept_c | step_c;

  // Sequencer FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (accept_c) begin
            cnt_q  <= CNT_W'(XLEN - 1);
            busy_q <= 1'b1;
            if (fast_c) begin
              state_q <= MD_DONE;
              done_q  <= 1'b1;
            end else if (funct3_i[2]) begin
              state_q <= MD_DIV;
            end else begin
              state_q <= MD_MUL;
            end
          end
        end
        MD_MUL, MD_DIV: begin
          if (flush_i) begin
            state_q <= MD_IDLE;
          end else if (last_c) begin
            state_q <= MD_DONE;
            busy_q  <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q - CNT_W'(1);
            busy_q <= 1'b1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

  ex_muldiv_sequencer_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept_c),
    .step_i   (step_c),
    .last_i   (last_c),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .fast_o   (fast_c),
    .result_o (result_o)
  );

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench: behavioural RV32M model plus directed and random ops.
module tb_ex_muldiv_sequencer;
  import ex_muldiv_sequencer_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i, op_b_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result, computed with 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = '0;
    case (f3)
      3'd0: begin p = 64'(ua * ub); r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: r = (b == 0) ? ONES : ((a == MINV && b == ONES) ? MINV : 32'($signed(a) / $signed(b)));
      3'd5: r = (b == 0) ? ONES : a / b;
      3'd6: r = (b == 0) ? a : ((a == MINV && b == ONES) ? 32'd0 : 32'($signed(a) % $signed(b)));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == MINV && b == ONES));
  endfunction

  // Timing model: idle -> XLEN busy cycles (or none on fast path) -> one done cycle
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t     m_st = M_IDLE;
  int          m_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res = '0;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    cmp_en = 1'b1;
    if (!rst_n) begin
      m_st  = M_IDLE;
      m_res = '0;
    end else begin
      case (m_st)
        M_IDLE: if (start_i && !flush_i) begin
          if (is_fast(funct3_i, op_a_i, op_b_i)) begin
            m_st  = M_DONE;
            m_res = ref_result(funct3_i, op_a_i, op_b_i);
          end else begin
            m_st   = M_RUN;
            m_left = XLEN;
            m_pend = ref_result(funct3_i, op_a_i, op_b_i);
          end
        end
        M_RUN: begin
          if (flush_i) m_st = M_IDLE;
          else begin
            m_left--;
            if (m_left == 0) begin
              m_st  = M_DONE;
              m_res = m_pend;
            end
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", 32'(stall_o),
          32'((m_st == M_IDLE && start_i && !flush_i) || (m_st == M_RUN && !flush_i)));
      chk("busy", 32'(busy_o), 32'(m_st != M_IDLE));
      chk("done", 32'(done_o), 32'(m_st == M_DONE));
      chk("result", result_o, m_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    tick();
    start_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (done_o === 1'b1) begin seen = 1'b1; n = i; end
    end
    start_i = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no done expected done by cycle 40", name);
    end else begin
      chk({name, "_result"}, result_o, exp);
      chk({name, "_latency"}, 32'(n), 32'(lat));
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return MINV;
      2: return ONES;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic new_op();
    start_i  = 1'b1;
    funct3_i = 3'($urandom_range(0, 7));
    op_a_i   = rand_opnd();
    op_b_i   = rand_opnd();
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; op_a_i = '0; op_b_i = '0;

    // Model pinned against hand-computed values
    chk("model_mul",  ref_result(F3_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model_div",  ref_result(F3_DIV, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFA);
    chk("model_rem",  ref_result(F3_REM, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
    chk("model_mulhu", ref_result(F3_MULHU, ONES, ONES), 32'hFFFF_FFFE);

    // Reset state
    tick(); tick();
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst_n = 1'b1;

    run_op("mul",    F3_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh",   F3_MULH,   32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_op("mulhu",  F3_MULHU,  ONES, ONES, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", F3_MULHSU, ONES, ONES, 32'hFFFF_FFFF, 33);
    run_op("div",    F3_DIV,    32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_op("rem",    F3_REM,    32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_op("divu",   F3_DIVU,   32'd100, 32'd7, 32'd14, 33);
    run_op("remu",   F3_REMU,   32'd100, 32'd7, 32'd2, 33);
    run_op("divu0",  F3_DIVU,   32'd5, 32'd0, ONES, 1);
    run_op("rem0",   F3_REM,    32'd5, 32'd0, 32'd5, 1);
    run_op("removf", F3_REM,    MINV, ONES, 32'd0, 1);
    run_op("divovf", F3_DIV,    MINV, ONES, MINV, 1);

    // Flush in cycle 10 of a DIV
    tick();
    start_i = 1'b1; funct3_i = F3_DIV; op_a_i = 32'hFFFF_FFEC; op_b_i = 32'd3;
    for (int i = 1; i <= 9; i++) tick();
    tick();
    flush_i = 1'b1; start_i = 1'b0;
    tick();
    flush_i = 1'b0;
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_done", 32'(done_o), 32'd0);
    chk("flush_result", result_o, MINV);
    run_op("mul3x4", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

    // A changed funct3/operands while busy must not disturb the running MUL
    tick();
    start_i = 1'b1; funct3_i = F3_MUL; op_a_i = 32'd7; op_b_i = 32'hFFFF_FFFD;
    seen = 1'b0; n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (done_o === 1'b1) begin seen = 1'b1; n = i; end
      if (i == 5) begin funct3_i = F3_DIVU; op_a_i = 32'd100; op_b_i = 32'd7; end
    end
    start_i = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL ignore_timeout: got no done expected done by cycle 40");
    end else begin
      chk("ignore_result", result_o, 32'hFFFF_FFEB);
      chk("ignore_latency", 32'(n), 32'd33);
    end

    // Reset in cycle 5 of a MUL
    tick();
    start_i = 1'b1; funct3_i = F3_MUL; op_a_i = 32'd5; op_b_i = 32'd9;
    for (int i = 1; i <= 4; i++) tick();
    tick();
    rst_n = 1'b0; start_i = 1'b0;
    tick();
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    rst_n = 1'b1;

    // Random traffic: back-to-back ops, idle gaps, flushes and start+flush collisions
    for (int c = 0; c < 4000; c++) begin
      tick();
      flush_i = 1'b0;
      if (done_o === 1'b1) begin
        if ($urandom_range(0, 1) == 1) new_op();
        else start_i = 1'b0;
      end else if (busy_o === 1'b1) begin
        if ($urandom_range(0, 49) == 0) begin flush_i = 1'b1; start_i = 1'b0; end
      end else if (!start_i) begin
        if ($urandom_range(0, 1) == 1) begin
          new_op();
          if ($urandom_range(0, 9) == 0) flush_i = 1'b1;
        end
      end
    end
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
